apb_top: RTL and testbench

- Self-contained APB subsystem: an APB master FSM (IDLE/SETUP/ACCESS) driving an internal APB slave register-file memory over an internal PSEL/PENABLE/PREADY bus.
- A host requests transfers through TRANSFER/PWRITE/PADDR/PWDATA. Read data returns on PRDATA.
- Used as a top-level APB protocol demonstrator and as a bus-model block.

---
 rtl/apb_top.sv | 138 +++++++++++++
 tb/tb_apb_top.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_top.sv
// APB subsystem: an APB master FSM (IDLE/SETUP/ACCESS) driving an internal
// register-file slave over an internal PSEL/PENABLE/PREADY bus.
//
// Parameters:
//   MEM_DEPTH   - number of 32-bit words in the slave memory
//   WAIT_STATES - ACCESS cycles the slave holds PREADY low (0..15)
//
// Ports:
//   clk      - system clock, rising-edge active
//   rst_n    - asynchronous active-low reset
//   TRANSFER - host request; high = perform or continue transfers
//   PADDR    - byte address of the transfer (word index = PADDR[9:2])
//   PWDATA   - write data
//   PWRITE   - 1 = write, 0 = read
//   PRDATA   - data of the last completed read
module apb_top #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        TRANSFER,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  output logic [31:0] PRDATA
);

  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;

  // Master state and latched transfer
  logic [1:0]  state_q, state_d;
  logic [7:0]  word_q, word_d;     // PADDR[9:2]; other address bits are never decoded
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;

  // Slave state
  logic [3:0]  wait_q, wait_d;
  logic [31:0] prdata_q, prdata_d;
  logic [31:0] mem_q [MEM_DEPTH];

  // Internal APB bus
  logic           psel;
  logic           penable;
  logic           pready;
  logic           done;
  logic           capture;
  logic [IdxW-1:0] mem_idx;
  logic [31:0]    rdata;

  assign psel    = (state_q == StSetup) || (state_q == StAccess);
  assign penable = (state_q == StAccess);
  assign pready  = psel && penable && (wait_q == 4'(WAIT_STATES));
  assign done    = penable && pready;

  // A new request is accepted from IDLE, or on the completing ACCESS edge
  // so that back-to-back transfers skip IDLE entirely.
  assign capture = TRANSFER && ((state_q == StIdle) || done);

  // Upper address bits alias: the index wraps modulo the memory depth.
  assign mem_idx = IdxW'(32'(word_q) % MEM_DEPTH);
  assign rdata   = mem_q[mem_idx];

  // Master next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (TRANSFER) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready) state_d = TRANSFER ? StSetup : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Latched transfer values stay frozen from SETUP through completion.
  always_comb begin
    word_d  = word_q;
    wdata_d = wdata_q;
    write_d = write_q;
    if (capture) begin
      word_d  = PADDR[9:2];
      wdata_d = PWDATA;
      write_d = PWRITE;
    end
  end

  // Wait counter runs only while ACCESS is stalled.
  always_comb begin
    wait_d = '0;
    if (penable && !pready) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // Read data is captured only on a completing read; writes leave it alone.
  always_comb begin
    prdata_d = prdata_q;
    if (done && !write_q) begin
      prdata_d = rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      word_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      wait_q   <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      wait_q   <= wait_d;
      prdata_q <= prdata_d;
    end
  end

  // Slave register file; cleared on reset, an aborted write never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (done && write_q) begin
      mem_q[mem_idx] <= wdata_q;
    end
  end

  assign PRDATA = prdata_q;

endmodule

// File: tb/tb_apb_top.sv
module tb_apb_top;

  logic        clk;
  logic        rst_n;
  logic        tr0, tr1;
  logic        we0, we1;
  logic [31:0] pa0, pa1;
  logic [31:0] pw0, pw1;
  logic [31:0] prd0, prd1;

  int n_tests;
  int n_fail;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] dt;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] mm [2][256];
  logic [31:0] m_prd [2];
  int          ws [2];

  apb_top #(.MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .TRANSFER (tr0),
    .PADDR    (pa0),
    .PWDATA   (pw0),
    .PWRITE   (we0),
    .PRDATA   (prd0)
  );

  apb_top #(.MEM_DEPTH(256), .WAIT_STATES(3)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .TRANSFER (tr1),
    .PADDR    (pa1),
    .PWDATA   (pw1),
    .PWRITE   (we1),
    .PRDATA   (prd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("prdata_ws0", prd0, m_prd[0]);
    chk("prdata_ws3", prd1, m_prd[1]);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mm[d][i] = '0;
      m_prd[d] = '0;
    end
  endtask

  // Word index: byte offset dropped, upper bits wrap modulo 256 words.
  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFF) % 256;
  endfunction

  task automatic model_apply(input int d, input xfer_t x);
    if (x.we) mm[d][widx(x.a)] = x.dt;
    else      m_prd[d] = mm[d][widx(x.a)];
  endtask

  task automatic drive(input int d, input logic en, input logic w,
                       input logic [31:0] a, input logic [31:0] dt);
    if (d == 0) begin
      tr0 = en; we0 = w; pa0 = a; pw0 = dt;
    end else begin
      tr1 = en; we1 = w; pa1 = a; pw1 = dt;
    end
  endtask

  // Host inputs during SETUP/ACCESS must not disturb the transfer in flight.
  task automatic garbage(input int d);
    drive(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic add(input bit w, input logic [31:0] a, input logic [31:0] dt);
    xfer_t x;
    x.we = w; x.a = a; x.dt = dt;
    q.push_back(x);
  endtask

  // Runs the queued transfers back-to-back: each completion edge is the
  // sample edge of the next request, each transfer takes 2 + wait cycles.
  task automatic run_burst(input int d);
    int n;
    n = q.size();
    drive(d, 1'b1, q[0].we, q[0].a, q[0].dt);
    step();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 1 + ws[d]; k++) begin
        garbage(d);
        step();
      end
      if (i + 1 < n) drive(d, 1'b1, q[i+1].we, q[i+1].a, q[i+1].dt);
      else           drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      model_apply(d, q[i]);
      @(negedge clk);
      check_all();
    end
    q.delete();
  endtask

  function automatic logic [31:0] raddr();
    return ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ws[0]   = 0;
    ws[1]   = 3;
    rst_n   = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();

    // Reset held for 10 cycles
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("reset_prdata0", prd0, 32'h0);
    chk("reset_prdata1", prd1, 32'h0);
    rst_n = 1'b1;
    step();

    add(1'b0, 32'h100, 32'h0);
    run_burst(0);
    chk("read_after_reset", prd0, 32'h0);

    // Single write then read, PRDATA valid 2 cycles after request sampled
    add(1'b1, 32'h100, 32'hDEADBEEF);
    run_burst(0);
    step();
    add(1'b0, 32'h100, 32'h0);
    run_burst(0);
    chk("wr_rd_0x100", prd0, 32'hDEADBEEF);

    // Back-to-back without IDLE
    add(1'b1, 32'h004, 32'h11111111);
    add(1'b1, 32'h008, 32'h22222222);
    add(1'b0, 32'h004, 32'h0);
    run_burst(0);
    chk("b2b_rd_0x004", prd0, 32'h11111111);
    add(1'b0, 32'h008, 32'h0);
    run_burst(0);
    chk("b2b_rd_0x008", prd0, 32'h22222222);

    // Aliasing and byte offset
    add(1'b1, 32'h403, 32'hA5A5A5A5);
    add(1'b0, 32'h000, 32'h0);
    run_burst(0);
    chk("alias_rd_0x000", prd0, 32'hA5A5A5A5);

    // Wait states: PRDATA must hold old value through the stall
    add(1'b1, 32'h100, 32'hCAFEF00D);
    add(1'b1, 32'h200, 32'h0BADC0DE);
    add(1'b0, 32'h200, 32'h0);
    run_burst(1);
    chk("ws3_rd_0x200", prd1, 32'h0BADC0DE);
    add(1'b0, 32'h100, 32'h0);
    run_burst(1);
    chk("ws3_rd_0x100", prd1, 32'hCAFEF00D);

    // Randomized bursts on both wait-state configurations
    for (int r = 0; r < 40; r++) begin
      int d;
      int n;
      d = r % 2;
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) add(1'($urandom_range(0, 1)), raddr(), $urandom);
      run_burst(d);
      if ($urandom_range(0, 1) == 1) step();
    end

    // Reset during ACCESS of a write: write dropped, everything cleared
    drive(0, 1'b1, 1'b1, 32'h010, 32'h12345678);
    step();
    garbage(0);
    tr0 = 1'b0;
    step();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    model_reset();
    chk("async_reset_prdata0", prd0, 32'h0);
    chk("async_reset_prdata1", prd1, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    add(1'b0, 32'h010, 32'h0);
    run_burst(0);
    chk("aborted_write_0x010", prd0, 32'h0);
    add(1'b0, 32'h004, 32'h0);
    run_burst(0);
    chk("mem_cleared_0x004", prd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
